// File: rtl/piarb_topic_value_arb.sv
// Purpose: shares one single-port topic value memory between a PIO agent and N_REQ lookup requesters.
// Latency: PIO issues 1 cycle after its strobe and acks 2 cycles later; lookup data returns 1 cycle after grant.
// Backpressure: PIO preempts lookups in its issue cycle; lookup requesters hold lu_req until granted.
module piarb_topic_value_arb #(
  parameter int N_REQ = 4,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_div,
  input  logic                reg_ms_topic_value,
  input  logic                reg_rd,
  input  logic                reg_wr,
  input  logic [AW-1:0]       reg_addr,
  input  logic [DW-1:0]       reg_din,
  output logic                topic_value_mem_ack,
  output logic [DW-1:0]       topic_value_mem_rdata,
  input  logic [N_REQ-1:0]    lu_req,
  input  logic [N_REQ*AW-1:0] lu_addr,
  output logic [N_REQ-1:0]    lu_gnt,
  output logic [N_REQ-1:0]    lu_rvalid,
  output logic [DW-1:0]       lu_rdata,
  output logic                mem_en,
  output logic                mem_wr,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // Captured PIO request, held from the strobe until the FSM returns to IDLE.
  logic [AW-1:0]   pio_addr;
  logic [DW-1:0]   pio_din;
  logic            pio_wr;

  logic            pio_start;
  logic            pio_issue;

  // Round-robin arbiter state and per-cycle decision.
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            arb_en;
  int              scan_idx;

  // A strobe only starts an access when the FSM is idle and the decode hits this memory.
  assign pio_start = (reg_rd | reg_wr) & reg_ms_topic_value & (state == S_IDLE) & ~rst;

  // The issue cycle owns the memory port; reset cycles drive nothing.
  assign pio_issue = (state == S_ISSUE) & ~rst;

  // Lookups may use every non-issue cycle.
  assign arb_en = gnt_any & ~pio_issue & ~rst;

  // PIO FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // PIO FSM next state: fixed IDLE->ISSUE->CAPTURE->ACK walk, ACK waits for the PIO sample strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pio_start) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_nxt = S_ACK;
      end
      S_ACK: begin
        if (clk_div) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch address, data and direction of an accepted PIO strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pio_addr <= '0;
      pio_din  <= '0;
      pio_wr   <= 1'b0;
    end else if (pio_start) begin
      pio_addr <= reg_addr;
      pio_din  <= reg_din;
      pio_wr   <= reg_wr;
    end
  end

  // PIO read data register: loads memory data in CAPTURE for reads, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      topic_value_mem_rdata <= '0;
    end else if ((state == S_CAPTURE) && !pio_wr) begin
      topic_value_mem_rdata <= mem_rdata;
    end
  end

  // Ack is a level that stays up for the whole ACK state, so the slow PIO side can sample it.
  assign topic_value_mem_ack = (state == S_ACK) & ~rst;

  // Round-robin scan: first requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= N_REQ) begin
        scan_idx = scan_idx - N_REQ;
      end
      if (!gnt_any && lu_req[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx[PW-1:0];
      end
    end
  end

  // One-hot grant pulse for the winning requester.
  always_comb begin
    lu_gnt = '0;
    if (arb_en) begin
      lu_gnt[gnt_idx] = 1'b1;
    end
  end

  // Pointer moves just past the winner; it stays put in cycles without a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (arb_en) begin
      if (gnt_idx == PW'(N_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= gnt_idx + 1'b1;
      end
    end
  end

  // Read-data-valid follows the grant by the memory's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_rvalid <= '0;
    end else begin
      lu_rvalid <= lu_gnt;
    end
  end

  // Lookup data bus is forced to zero whenever no requester is being returned data.
  assign lu_rdata = (|lu_rvalid) ? mem_rdata : '0;

  // Memory port mux: PIO issue wins, else the lookup winner, else everything idles at zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (pio_issue) begin
      mem_en    = 1'b1;
      mem_wr    = pio_wr;
      mem_addr  = pio_addr;
      mem_wdata = pio_din;
    end else if (arb_en) begin
      mem_en    = 1'b1;
      mem_addr  = lu_addr[int'(gnt_idx)*AW +: AW];
    end
  end

endmodule

// File: tb/tb_piarb_topic_value_arb.sv
// Purpose: checks the memory arbiter cycle by cycle against a transaction-level reference.
// Latency: every cycle is compared at the falling edge after inputs settle.
// Backpressure: lookup requests are held by the bench until the reference grants them.
module tb_piarb_topic_value_arb;

  localparam int N_REQ = 4;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clk_div = 1'b0;
  logic                reg_ms_topic_value = 1'b0;
  logic                reg_rd = 1'b0;
  logic                reg_wr = 1'b0;
  logic [AW-1:0]       reg_addr = '0;
  logic [DW-1:0]       reg_din = '0;
  logic                topic_value_mem_ack;
  logic [DW-1:0]       topic_value_mem_rdata;
  logic [N_REQ-1:0]    lu_req = '0;
  logic [N_REQ*AW-1:0] lu_addr = '0;
  logic [N_REQ-1:0]    lu_gnt;
  logic [N_REQ-1:0]    lu_rvalid;
  logic [DW-1:0]       lu_rdata;
  logic                mem_en;
  logic                mem_wr;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata = '0;

  piarb_topic_value_arb #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .clk_div               (clk_div),
    .reg_ms_topic_value    (reg_ms_topic_value),
    .reg_rd                (reg_rd),
    .reg_wr                (reg_wr),
    .reg_addr              (reg_addr),
    .reg_din               (reg_din),
    .topic_value_mem_ack   (topic_value_mem_ack),
    .topic_value_mem_rdata (topic_value_mem_rdata),
    .lu_req                (lu_req),
    .lu_addr               (lu_addr),
    .lu_gnt                (lu_gnt),
    .lu_rvalid             (lu_rvalid),
    .lu_rdata              (lu_rdata),
    .mem_en                (mem_en),
    .mem_wr                (mem_wr),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_rdata             (mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory seen by the DUT (driven purely by its port) and the reference's own copy.
  logic [DW-1:0] env_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  // Reference: PIO transaction progress counted in cycles since the strobe (0 = none pending).
  int            r_pio_age;
  logic          r_pio_wr;
  logic [AW-1:0] r_pio_addr;
  logic [DW-1:0] r_pio_din;
  logic [DW-1:0] r_pio_read;
  logic [DW-1:0] r_rdata;
  int            r_ptr;
  int            r_ret_who;
  logic [DW-1:0] r_ret_dat;
  int            r_gnt;

  // Captured memory command for the environment memory.
  logic          c_en;
  logic          c_wr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge, advance the reference at posedge, then answer the memory.
  task automatic cyc();
    logic           e_issue;
    logic           e_en;
    logic           e_wr;
    logic [AW-1:0]  e_addr;
    logic [DW-1:0]  e_wdata;
    logic [N_REQ-1:0] e_gnt;
    logic [N_REQ-1:0] e_rv;
    @(negedge clk);
    e_issue = !rst && (r_pio_age == 1);
    r_gnt = -1;
    if (!rst && !e_issue) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (r_gnt < 0 && lu_req[(r_ptr + k) % N_REQ]) r_gnt = (r_ptr + k) % N_REQ;
      end
    end
    e_gnt = '0;
    if (r_gnt >= 0) e_gnt[r_gnt] = 1'b1;
    e_en    = e_issue || (r_gnt >= 0);
    e_wr    = e_issue && r_pio_wr;
    e_addr  = e_issue ? r_pio_addr : ((r_gnt >= 0) ? lu_addr[r_gnt*AW +: AW] : '0);
    e_wdata = e_issue ? r_pio_din : '0;
    e_rv    = '0;
    if (r_ret_who >= 0) e_rv[r_ret_who] = 1'b1;
    chk("lu_gnt",    64'(lu_gnt),    64'(e_gnt));
    chk("mem_en",    64'(mem_en),    64'(e_en));
    chk("mem_wr",    64'(mem_wr),    64'(e_wr));
    chk("mem_addr",  64'(mem_addr),  64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    chk("ack",       64'(topic_value_mem_ack), 64'(!rst && r_pio_age >= 3));
    chk("pio_rdata", 64'(topic_value_mem_rdata), 64'(r_rdata));
    chk("lu_rvalid", 64'(lu_rvalid), 64'(e_rv));
    chk("lu_rdata",  64'(lu_rdata),  64'((r_ret_who >= 0) ? r_ret_dat : '0));
    c_en = mem_en; c_wr = mem_wr; c_addr = mem_addr; c_wdata = mem_wdata;
    @(posedge clk);
    if (rst) begin
      r_pio_age = 0; r_pio_wr = 1'b0; r_pio_addr = '0; r_pio_din = '0;
      r_rdata = '0; r_ptr = 0; r_ret_who = -1;
    end else begin
      r_ret_who = r_gnt;
      if (r_gnt >= 0) begin
        r_ret_dat = ref_mem[lu_addr[r_gnt*AW +: AW]];
        r_ptr = (r_gnt + 1) % N_REQ;
      end
      if (r_pio_age == 0) begin
        if ((reg_rd || reg_wr) && reg_ms_topic_value) begin
          r_pio_age = 1; r_pio_wr = reg_wr; r_pio_addr = reg_addr; r_pio_din = reg_din;
        end
      end else if (r_pio_age == 1) begin
        if (r_pio_wr) ref_mem[r_pio_addr] = r_pio_din;
        else r_pio_read = ref_mem[r_pio_addr];
        r_pio_age = 2;
      end else if (r_pio_age == 2) begin
        if (!r_pio_wr) r_rdata = r_pio_read;
        r_pio_age = 3;
      end else if (clk_div) begin
        r_pio_age = 0;
      end
    end
    #1;
    if (c_en && c_wr) env_mem[c_addr] = c_wdata;
    mem_rdata = (c_en && !c_wr) ? env_mem[c_addr] : $urandom();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic strobe(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ms);
    reg_ms_topic_value = ms; reg_wr = wr; reg_rd = !wr; reg_addr = a; reg_din = d;
    cyc();
    reg_rd = 1'b0; reg_wr = 1'b0; reg_ms_topic_value = 1'b0;
  endtask

  // Full PIO access with the sample strobe arriving on the fifth cycle after the request.
  task automatic pio(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    strobe(wr, a, d, 1'b1);
    run(4);
    clk_div = 1'b1; cyc(); clk_div = 1'b0;
    cyc();
  endtask

  task automatic rand_lu_addr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    lu_addr = t[N_REQ*AW-1:0];
  endtask

  initial begin
    r_pio_age = 0; r_pio_wr = 1'b0; r_pio_addr = '0; r_pio_din = '0; r_pio_read = '0;
    r_rdata = '0; r_ptr = 0; r_ret_who = -1; r_ret_dat = '0; r_gnt = -1;
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = $urandom();
      ref_mem[i] = env_mem[i];
    end
    env_mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;

    // Reset with a strobe present: it must be dropped.
    rst = 1'b1; reg_rd = 1'b1; reg_ms_topic_value = 1'b1; reg_addr = 10'h005;
    run(2);
    rst = 1'b0; reg_rd = 1'b0; reg_ms_topic_value = 1'b0;
    run(2);

    // PIO read of 0xDEADBEEF, then write and readback.
    pio(1'b0, 10'h005, '0);
    chk("rd_deadbeef", 64'(topic_value_mem_rdata), 64'h0000_0000_DEAD_BEEF);
    pio(1'b1, 10'h010, 32'h12345678);
    chk("wr_keeps_rdata", 64'(topic_value_mem_rdata), 64'h0000_0000_DEAD_BEEF);
    pio(1'b0, 10'h010, '0);
    chk("readback", 64'(topic_value_mem_rdata), 64'h0000_0000_1234_5678);

    // All requesters busy for 8 cycles: strict rotation.
    lu_req = 4'b1111;
    for (int i = 0; i < 8; i++) begin rand_lu_addr(); cyc(); end
    lu_req = '0;
    run(2);

    // Two requesters plus a PIO read in the middle.
    lu_req = 4'b0101; rand_lu_addr();
    run(3);
    pio(1'b0, 10'h005, '0);
    run(3);
    lu_req = '0;
    run(1);

    // Ignored strobes: write during ACK, read with decode miss.
    strobe(1'b0, 10'h010, '0, 1'b1);
    run(2);
    strobe(1'b1, 10'h005, 32'h0BADF00D, 1'b1);
    clk_div = 1'b1; cyc(); clk_div = 1'b0;
    strobe(1'b0, 10'h005, '0, 1'b0);
    run(2);

    // Reset during CAPTURE, then a normal read.
    lu_req = 4'b0011; rand_lu_addr();
    strobe(1'b0, 10'h005, '0, 1'b1);
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    lu_req = '0;
    clk_div = 1'b1; run(3); clk_div = 1'b0;
    pio(1'b0, 10'h010, '0);
    chk("post_rst_read", 64'(topic_value_mem_rdata), 64'h0000_0000_1234_5678);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 120) == 0);
      clk_div = ($urandom_range(0, 3) == 0);
      reg_ms_topic_value = ($urandom_range(0, 4) != 0);
      reg_rd = 1'b0; reg_wr = 1'b0;
      case ($urandom_range(0, 5))
        0: reg_rd = 1'b1;
        1: reg_wr = 1'b1;
        default: ;
      endcase
      reg_addr = 10'($urandom_range(0, 31));
      reg_din  = $urandom();
      lu_req   = 4'($urandom_range(0, 15));
      rand_lu_addr();
      lu_addr[AW-1:0] = 10'($urandom_range(0, 31));
      cyc();
    end
    rst = 1'b0; reg_rd = 1'b0; reg_wr = 1'b0; lu_req = '0; clk_div = 1'b1;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
